// File: rtl/machine_ctrl_if.sv
// Control-path bundle between the instruction sequencer and the CPU datapath.
// The master side is the sequencer; the slave side is the datapath/instruction register.
interface machine_ctrl_if;
    localparam int unsigned OP_W = 3;
    localparam int unsigned ST_W = 4;

    logic            ena;
    logic [OP_W-1:0] opcode;
    logic            zero;
    logic            load_ir;
    logic            rd;
    logic            wr;
    logic            inc_pc;
    logic            load_pc;
    logic            load_acc;
    logic            datactl_ena;
    logic            halt;
    logic [ST_W-1:0] state_o;

    modport master (
        input  ena, opcode, zero,
        output load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt, state_o
    );

    modport slave (
        output ena, opcode, zero,
        input  load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt, state_o
    );
endinterface

// File: rtl/machine_ctrl.sv
// Instruction sequencer: fixed 7-cycle fetch/decode/execute sequence per instruction,
// HLT parks in HALT until reset. Strobes are registered, decoded from the next state.
module machine_ctrl (
    input  logic           clk,
    input  logic           rst,
    machine_ctrl_if.master bus
);
    localparam int unsigned OP_W = 3;
    localparam int unsigned ST_W = 4;

    localparam logic [OP_W-1:0] OP_HLT = 3'b000;
    localparam logic [OP_W-1:0] OP_SKZ = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_AND = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_LDA = 3'b101;
    localparam logic [OP_W-1:0] OP_STO = 3'b110;
    localparam logic [OP_W-1:0] OP_JMP = 3'b111;

    typedef enum logic [ST_W-1:0] {
        IDLE = 4'd0,
        F0   = 4'd1,
        F1   = 4'd2,
        DEC  = 4'd3,
        EX1  = 4'd4,
        EX2  = 4'd5,
        EX3  = 4'd6,
        WB   = 4'd7,
        HALT = 4'd8
    } state_e;

    typedef struct packed {
        logic load_ir;
        logic rd;
        logic wr;
        logic inc_pc;
        logic load_pc;
        logic load_acc;
        logic datactl_ena;
        logic halt;
    } ctrl_t;

    state_e state_q;
    state_e state_d;
    logic   zero_q;
    logic   zero_d;
    ctrl_t  ctrl_q;

    function automatic state_e next_state(state_e s, logic ena, logic [OP_W-1:0] op);
        if (s == HALT) return HALT;
        if (!ena)      return IDLE;
        case (s)
            IDLE:    return F0;
            F0:      return F1;
            F1:      return DEC;
            DEC:     return (op == OP_HLT) ? HALT : EX1;
            EX1:     return EX2;
            EX2:     return EX3;
            EX3:     return WB;
            WB:      return F0;
            default: return IDLE;
        endcase
    endfunction

    function automatic ctrl_t decode(state_e s, logic [OP_W-1:0] op, logic z);
        ctrl_t c;
        logic  alu;
        c   = '0;
        alu = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
        case (s)
            F0, F1: begin
                c.load_ir = 1'b1;
                c.rd      = 1'b1;
                c.inc_pc  = 1'b1;
            end
            EX1: begin
                c.rd          = alu;
                c.datactl_ena = (op == OP_STO);
                c.load_pc     = (op == OP_JMP);
            end
            EX2: begin
                c.rd          = alu;
                c.load_acc    = alu;
                c.datactl_ena = (op == OP_STO);
                c.wr          = (op == OP_STO);
                c.load_pc     = (op == OP_JMP);
                c.inc_pc      = (op == OP_SKZ) && z;
            end
            EX3: begin
                c.rd          = alu;
                c.datactl_ena = (op == OP_STO);
                c.inc_pc      = (op == OP_SKZ) && z;
            end
            HALT:    c.halt = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    assign state_d = next_state(state_q, bus.ena, bus.opcode);
    // Skip condition is captured once, as the instruction leaves decode.
    assign zero_d  = (state_q == DEC && state_d == EX1) ? bus.zero : zero_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            zero_q  <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            zero_q  <= zero_d;
            ctrl_q  <= decode(state_d, bus.opcode, zero_d);
        end
    end

    assign bus.load_ir     = ctrl_q.load_ir;
    assign bus.rd          = ctrl_q.rd;
    assign bus.wr          = ctrl_q.wr;
    assign bus.inc_pc      = ctrl_q.inc_pc;
    assign bus.load_pc     = ctrl_q.load_pc;
    assign bus.load_acc    = ctrl_q.load_acc;
    assign bus.datactl_ena = ctrl_q.datactl_ena;
    assign bus.halt        = ctrl_q.halt;
    assign bus.state_o     = ST_W'(state_q);
endmodule

// File: tb/tb_machine_ctrl.sv
// Directed bench for machine_ctrl: instruction sequences, skip, halt and abort behaviour.
module tb_machine_ctrl;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    machine_ctrl_if bus ();

    machine_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: load_ir rd wr inc_pc load_pc load_acc datactl_ena halt
    logic [7:0] outs;
    assign outs = {bus.load_ir, bus.rd, bus.wr, bus.inc_pc,
                   bus.load_pc, bus.load_acc, bus.datactl_ena, bus.halt};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_step(input string tag, input logic [3:0] st, input logic [7:0] o);
        logic bad;
        bad = (bus.wr & bus.rd) | (bus.wr & ~bus.datactl_ena) | (bus.load_pc & bus.inc_pc);
        chk({tag, " state"}, {4'b0, bus.state_o}, {4'b0, st});
        chk({tag, " outs"}, outs, o);
        chk({tag, " invariant"}, {7'b0, bad}, 8'h00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one full instruction starting from IDLE or WB; checks F0..WB.
    task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                             input logic toggle_z,
                             input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp [7];
        exp = '{8'hD0, 8'hD0, 8'h00, e1, e2, e3, 8'h00};
        bus.opcode = op;
        bus.zero   = z;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_step($sformatf("%s[%0d]", tag, i), 4'(i + 1), exp[i]);
            if (toggle_z && i >= 3) bus.zero = ~bus.zero;
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst        = 1'b1;
        bus.ena    = 1'b0;
        bus.opcode = 3'b010;
        bus.zero   = 1'b0;

        tick();
        tick();
        check_step("reset", 4'd0, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_step($sformatf("idle[%0d]", i), 4'd0, 8'h00);
        end

        bus.ena = 1'b1;
        run_instr("add",    3'b010, 1'b0, 1'b0, 8'h40, 8'h44, 8'h40);
        run_instr("sto",    3'b110, 1'b0, 1'b0, 8'h02, 8'h22, 8'h02);
        run_instr("jmp",    3'b111, 1'b0, 1'b0, 8'h08, 8'h08, 8'h00);
        run_instr("skz_z1", 3'b001, 1'b1, 1'b1, 8'h00, 8'h10, 8'h10);
        run_instr("skz_z0", 3'b001, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        run_instr("lda",    3'b101, 1'b1, 1'b0, 8'h40, 8'h44, 8'h40);

        // Abort an ADD in EX2
        bus.opcode = 3'b010;
        tick(); check_step("abort_f0",  4'd1, 8'hD0);
        tick(); check_step("abort_f1",  4'd2, 8'hD0);
        tick(); check_step("abort_dec", 4'd3, 8'h00);
        tick(); check_step("abort_ex1", 4'd4, 8'h40);
        tick(); check_step("abort_ex2", 4'd5, 8'h44);
        bus.ena = 1'b0;
        tick(); check_step("abort_idle", 4'd0, 8'h00);
        bus.ena = 1'b1;
        tick(); check_step("restart_f0", 4'd1, 8'hD0);

        // HLT
        bus.opcode = 3'b000;
        tick(); check_step("hlt_f1",  4'd2, 8'hD0);
        tick(); check_step("hlt_dec", 4'd3, 8'h00);
        tick(); check_step("hlt",     4'd8, 8'h01);
        for (int i = 0; i < 10; i++) begin
            bus.ena = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            check_step($sformatf("halt_hold[%0d]", i), 4'd8, 8'h01);
        end
        rst = 1'b1;
        tick(); check_step("halt_rst", 4'd0, 8'h00);
        rst     = 1'b0;
        bus.ena = 1'b0;
        tick(); check_step("post_rst", 4'd0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
